// File: rtl/multiplier_seq_nibble.sv
// -----------------------------------------------------------------------------
// multiplier_seq_nibble
//   Iterative unsigned WIDTH x WIDTH multiplier with a one-time carry-in.
//   Each RUN cycle multiplies the multiplicand by one 4-bit digit of the
//   multiplier (least significant digit first) and adds the shifted digit
//   product into a 2*WIDTH accumulator. The final result is
//   PRODUCT = A*B + carry_in.
//
//   Parameters
//     WIDTH      operand width; multiple of 4 and >= 4 (N = WIDTH/4 digits)
//
//   Ports
//     clk        rising-edge clock
//     reset      synchronous active-high reset; wins over every other event
//     in_valid   A, B and carry_in are valid
//     in_ready   an operation can be accepted (IDLE only)
//     A          multiplicand, unsigned
//     B          multiplier, unsigned
//     carry_in   added once to the product
//     out_valid  PRODUCT and carry_out are valid (DONE)
//     out_ready  consumer takes the result
//     PRODUCT    registered 2*WIDTH-bit A*B + carry_in
//     carry_out  registered; 1 when the upper WIDTH bits of PRODUCT are non-zero
//
//   Timing: out_valid rises N clock edges after the accepting edge and stays
//   high with a stable result until out_ready is seen. No new operation is
//   accepted on the handoff edge.
// -----------------------------------------------------------------------------
module multiplier_seq_nibble #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 carry_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   PRODUCT,
    output logic                 carry_out
);

    localparam int N     = WIDTH / 4;
    // A 1-bit counter is kept even for N=1 so the vector never has zero width.
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [2*WIDTH-1:0] acc_r;
    // Multiplicand pre-shifted by 4*cnt, so the digit product lands in place
    // without a variable shifter.
    logic [2*WIDTH-1:0] mcand_r;
    // Multiplier shifted right one digit per RUN cycle; bits [3:0] are the
    // digit of the current step.
    logic [WIDTH-1:0]   mplier_r;

    logic [2*WIDTH-1:0] pp_s;
    logic [2*WIDTH-1:0] acc_nxt_s;
    logic               upper_nz_s;

    // Exact digit product: a (shifted) multiplicand times one 4-bit digit.
    // Computed at full 2*WIDTH so nothing is truncated.
    function automatic logic [2*WIDTH-1:0] digit_product(
        input logic [2*WIDTH-1:0] mcand,
        input logic [3:0]         digit
    );
        digit_product = mcand * {{(2*WIDTH-4){1'b0}}, digit};
    endfunction

    // Overflow flag for a WIDTH-bit truncation of the full product.
    function automatic logic upper_nonzero(input logic [2*WIDTH-1:0] value);
        upper_nonzero = |value[2*WIDTH-1:WIDTH];
    endfunction

    // Next accumulator value for the current RUN step and its overflow flag.
    // The sum cannot overflow 2*WIDTH bits: (2^W-1)^2 + 1 < 2^(2W).
    always_comb begin
        pp_s       = digit_product(mcand_r, mplier_r[3:0]);
        acc_nxt_s  = acc_r + pp_s;
        upper_nz_s = upper_nonzero(acc_nxt_s);
    end

    // Control FSM, datapath registers and registered handshake/result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            acc_r     <= {(2*WIDTH){1'b0}};
            mcand_r   <= {(2*WIDTH){1'b0}};
            mplier_r  <= {WIDTH{1'b0}};
            PRODUCT   <= {(2*WIDTH){1'b0}};
            carry_out <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        mcand_r  <= {{WIDTH{1'b0}}, A};
                        mplier_r <= B;
                        // carry_in enters here, once, and never per digit.
                        acc_r    <= {{(2*WIDTH-1){1'b0}}, carry_in};
                        cnt_r    <= CNT_ZERO;
                        in_ready <= 1'b0;
                        state_r  <= ST_RUN;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end

                ST_RUN: begin
                    acc_r    <= acc_nxt_s;
                    mcand_r  <= mcand_r << 3'd4;
                    mplier_r <= mplier_r >> 3'd4;
                    if (cnt_r == CNT_LAST) begin
                        // Last digit: publish the final sum directly so the
                        // result is valid on the DONE entry edge.
                        PRODUCT   <= acc_nxt_s;
                        carry_out <= upper_nz_s;
                        out_valid <= 1'b1;
                        cnt_r     <= CNT_ZERO;
                        state_r   <= ST_DONE;
                    end else begin
                        cnt_r     <= cnt_r + CNT_ONE;
                        state_r   <= ST_RUN;
                    end
                end

                ST_DONE: begin
                    // in_ready stays low through the handoff edge, so a
                    // pending in_valid is only taken on a later edge.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else begin
                        state_r   <= ST_DONE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    cnt_r     <= CNT_ZERO;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier_seq_nibble.sv
// -----------------------------------------------------------------------------
// tb_multiplier_seq_nibble
//   Directed and randomized bench for multiplier_seq_nibble at WIDTH=16 and
//   WIDTH=4. Expected results come from plain integer arithmetic
//   (A*B + carry_in) and the fixed handshake timing of the block.
// -----------------------------------------------------------------------------
module tb_multiplier_seq_nibble;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        in_valid16, in_ready16, cin16, out_valid16, out_ready16, cout16;
    logic [15:0] a16, b16;
    logic [31:0] prod16;

    logic        in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4;
    logic [3:0]  a4, b4;
    logic [7:0]  prod4;

    int n_cmp = 0;
    int n_err = 0;

    multiplier_seq_nibble #(.WIDTH(16)) u_dut16 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .A         (a16),
        .B         (b16),
        .carry_in  (cin16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .PRODUCT   (prod16),
        .carry_out (cout16)
    );

    multiplier_seq_nibble #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .A         (a4),
        .B         (b4),
        .carry_in  (cin4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .PRODUCT   (prod4),
        .carry_out (cout4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=16 operation; out_ready is held low for 'hold' cycles after
    // out_valid first rises, with junk in_valid traffic during the stall.
    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input int hold, input string tag);
        longint unsigned exp_p;
        logic            exp_c;
        int              lat;
        exp_p = 64'(a) * 64'(b) + 64'(cin);
        exp_c = (exp_p >> 16) != 64'd0;

        lat = 0;
        while (in_ready16 !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, "/ready"}, in_ready16, 1'b1);

        a16 = a; b16 = b; cin16 = cin; in_valid16 = 1'b1;
        out_ready16 = (hold == 0);
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
        check({tag, "/busy"}, in_ready16, 1'b0);

        lat = 0;
        while (out_valid16 !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, "/latency"}, lat, 4);
        check({tag, "/product"}, prod16, exp_p);
        check({tag, "/carry"}, cout16, exp_c);

        for (int i = 0; i < hold; i++) begin
            in_valid16 = 1'b1;
            a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
            @(posedge clk); #1;
            check({tag, "/stall_valid"}, out_valid16, 1'b1);
            check({tag, "/stall_product"}, prod16, exp_p);
            check({tag, "/stall_carry"}, cout16, exp_c);
            check({tag, "/stall_ready"}, in_ready16, 1'b0);
        end

        out_ready16 = 1'b1;
        @(posedge clk); #1;
        check({tag, "/handoff_valid"}, out_valid16, 1'b0);
        check({tag, "/handoff_ready"}, in_ready16, 1'b1);
        check({tag, "/idle_hold"}, prod16, exp_p);
        in_valid16 = 1'b0;
    endtask

    // One WIDTH=4 operation (single digit): result one edge after accept.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                        input string tag);
        longint unsigned exp_p;
        int              lat;
        exp_p = 64'(a) * 64'(b) + 64'(cin);

        a4 = a; b4 = b; cin4 = cin; in_valid4 = 1'b1; out_ready4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        check({tag, "/busy"}, in_ready4, 1'b0);
        lat = 0;
        while (out_valid4 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, "/latency"}, lat, 1);
        check({tag, "/product"}, prod4, exp_p);
        check({tag, "/carry"}, cout4, (exp_p >> 4) != 64'd0);
        @(posedge clk); #1;
        check({tag, "/handoff_valid"}, out_valid4, 1'b0);
        check({tag, "/handoff_ready"}, in_ready4, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = 16'd0; b16 = 16'd0; cin16 = 1'b0;
        in_valid4  = 1'b0; out_ready4  = 1'b0; a4  = 4'd0;  b4  = 4'd0;  cin4  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst16/in_ready", in_ready16, 1'b1);
        check("rst16/out_valid", out_valid16, 1'b0);
        check("rst16/product", prod16, 32'd0);
        check("rst16/carry", cout16, 1'b0);
        check("rst4/in_ready", in_ready4, 1'b1);
        check("rst4/out_valid", out_valid4, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;

        run16(16'h0003, 16'h0005, 1'b0, 0, "mul3x5");
        check("mul3x5/const", prod16, 32'h0000000F);

        run16(16'hFFFF, 16'hFFFF, 1'b1, 0, "max");
        check("max/const", prod16, 32'hFFFE0002);
        check("max/carry_const", cout16, 1'b1);

        run16(16'h1234, 16'h0000, 1'b1, 0, "zero_b");
        check("zero_b/const", prod16, 32'h00000001);

        run16(16'h00FF, 16'h0101, 1'b0, 5, "stall");
        check("stall/const", prod16, 32'h0000FFFF);

        // Abort an operation with reset two edges after it was accepted.
        a16 = 16'hABCD; b16 = 16'h1234; cin16 = 1'b0; in_valid16 = 1'b1; out_ready16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort/out_valid", out_valid16, 1'b0);
        check("abort/in_ready", in_ready16, 1'b1);
        check("abort/product", prod16, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("abort/no_pulse", out_valid16, 1'b0);
        end
        run16(16'h0002, 16'h0003, 1'b0, 0, "post_abort");
        check("post_abort/const", prod16, 32'd6);

        run4(4'hF, 4'hF, 1'b1, "w4_max");
        check("w4_max/const", prod4, 8'hE2);
        check("w4_max/carry_const", cout4, 1'b1);

        for (int i = 0; i < 20; i++) begin
            run16(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "rand16");
        end
        for (int i = 0; i < 12; i++) begin
            run4(4'($urandom), 4'($urandom), 1'($urandom), "rand4");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
